ifu_prefetch_queue: RTL and testbench

//  Parametrised instruction fetch unit with a prefetch queue. Issues back-to-back AXI-lite

---
 rtl/ifu_prefetch_queue_pkg.sv | 24 ++
 rtl/ifu_sync_fifo.sv | 61 ++++++
 rtl/ifu_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_ifu_prefetch_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_prefetch_queue_pkg.sv
// Shared defaults and sizing helpers for the IFU prefetch queue slice.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
package ifu_prefetch_queue_pkg;

    localparam int          DEF_XLEN       = 64;
    localparam int          DEF_ADDR_W     = 32;
    localparam int          DEF_BUS_W      = 64;
    localparam int          DEF_INST_W     = 32;
    localparam int          DEF_FIFO_DEPTH = 4;
    localparam int          DEF_MAX_OUT    = 2;
    localparam logic [63:0] DEF_RESET_PC   = 64'h8000_0000;

    // Bits needed to hold a count 0..n.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n entries.
    function automatic int ptr_bits(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with flush; head data is registered storage read at rd_ptr.
// Latency: an entry pushed at edge t is at the head from t onward (one cycle push-to-pop).
// Backpressure: push ignored when full, pop ignored when empty; flush overrides push and pop.
module ifu_sync_fifo
    import ifu_prefetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_dat,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [cnt_bits(DEPTH)-1:0] count
);

    localparam int PTR_W = ptr_bits(DEPTH);
    localparam int CNT_W = cnt_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch: credit-limited AXI-lite AR/R reads into a queue feeding the IDU (IFU_BYPASS_EN: empty-queue bypass).
// Latency: AR accept t, R beat t+k -> ifu_valid at t+k+1, or t+k when IFU_BYPASS_EN is defined.
// Backpressure: idu_ready low fills the queue; outstanding+occupancy credits stop AR issue so RREADY stays 1.
module ifu_prefetch_queue
    import ifu_prefetch_queue_pkg::*;
#(
    parameter int              XLEN            = DEF_XLEN,
    parameter int              ADDR_W          = DEF_ADDR_W,
    parameter int              BUS_W           = DEF_BUS_W,
    parameter int              INST_W          = DEF_INST_W,
    parameter int              FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int              MAX_OUTSTANDING = DEF_MAX_OUT,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              isIntrPC,
    input  logic [XLEN-1:0]   IntrPC,
    input  logic              is_jump,
    input  logic [XLEN-1:0]   JumpPc,
    output logic              ARVALID,
    output logic [ADDR_W-1:0] ARADDR,
    input  logic              ARREADY,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [BUS_W-1:0]  inst_i,
    output logic              ifu_valid,
    input  logic              idu_ready,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   pc_o
);

    localparam int OUT_W  = cnt_bits(MAX_OUTSTANDING);
    localparam int CNT_W  = cnt_bits(FIFO_DEPTH);
    localparam int LANE_W = ptr_bits(BUS_W / INST_W);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } qent_t;

    logic [XLEN-1:0]   fetch_pc, redir_pc, target, tag_pc;
    logic [OUT_W-1:0]  outstanding, drop_cnt, out_nxt, tag_count;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    credit_used;
    logic [LANE_W-1:0] lane;
    logic              run, redir_pend, redirect, ar_fire, r_fire, ar_stall;
    logic              beat_ok, take_bypass, q_empty, q_full, q_push, q_pop;
    logic              tag_full, tag_empty;
    qent_t             beat, q_head, out_ent;

    assign redirect = isIntrPC | is_jump;
    assign target   = isIntrPC ? IntrPC : JumpPc;

    // run holds AR off during reset and its first cycle out of reset.
    assign credit_used = (CNT_W+1)'(q_count) + (CNT_W+1)'(outstanding);
    assign ARVALID     = run & (credit_used < (CNT_W+1)'(FIFO_DEPTH))
                             & (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign ARADDR      = fetch_pc[ADDR_W-1:0];
    assign RREADY      = 1'b1;

    assign ar_fire  = ARVALID & ARREADY;
    assign ar_stall = ARVALID & ~ARREADY;
    assign r_fire   = RVALID;
    assign out_nxt  = outstanding + OUT_W'(ar_fire) - OUT_W'(r_fire);

    assign lane      = tag_pc[2 +: LANE_W];
    assign beat.pc   = tag_pc;
    assign beat.inst = inst_i[INST_W*lane +: INST_W];
    assign beat_ok   = r_fire & ~redirect & (drop_cnt == '0);

`ifdef IFU_BYPASS_EN
    assign take_bypass = beat_ok & q_empty & idu_ready;
    assign ifu_valid   = ~q_empty | beat_ok;
    assign out_ent     = q_empty ? beat : q_head;
`else
    assign take_bypass = 1'b0;
    assign ifu_valid   = ~q_empty;
    assign out_ent     = q_head;
`endif

    assign inst_o = ifu_valid ? out_ent.inst : '0;
    assign pc_o   = ifu_valid ? out_ent.pc   : '0;
    assign q_push = beat_ok & ~take_bypass;
    assign q_pop  = ~q_empty & idu_ready;

    ifu_sync_fifo #(.WIDTH(XLEN + INST_W), .DEPTH(FIFO_DEPTH)) u_inst_q (
        .clk(clk), .rst_n(rst_n),
        .push(q_push), .push_dat(beat), .pop(q_pop), .head_dat(q_head),
        .flush(redirect), .full(q_full), .empty(q_empty), .count(q_count)
    );

    ifu_sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
        .clk(clk), .rst_n(rst_n),
        .push(ar_fire), .push_dat(fetch_pc), .pop(r_fire), .head_dat(tag_pc),
        .flush(1'b0), .full(tag_full), .empty(tag_empty), .count(tag_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            redir_pc    <= RESET_PC;
            redir_pend  <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= out_nxt;
            if (redirect) begin
                // A stalled AR keeps its old address; it becomes stale when accepted.
                drop_cnt   <= out_nxt;
                redir_pend <= ar_stall;
                redir_pc   <= target;
                if (!ar_stall) fetch_pc <= target;
            end else begin
                drop_cnt <= drop_cnt - OUT_W'(r_fire && drop_cnt != '0)
                                     + OUT_W'(ar_fire && redir_pend);
                if (ar_fire) begin
                    redir_pend <= 1'b0;
                    fetch_pc   <= redir_pend ? redir_pc : fetch_pc + XLEN'(4);
                end
            end
        end
    end

    a_out_bound:  assert property (@(posedge clk) disable iff (!rst_n)
                      outstanding <= OUT_W'(MAX_OUTSTANDING));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
                      drop_cnt <= OUT_W'(MAX_OUTSTANDING));
    a_tag_sync:   assert property (@(posedge clk) disable iff (!rst_n)
                      (tag_count == outstanding) && !(r_fire && tag_empty) && !(ar_fire && tag_full));
    a_no_ovf:     assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue with a simple in-order imem responder.
module tb_ifu_prefetch_queue;

    localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        isIntrPC = 1'b0, is_jump = 1'b0;
    logic [63:0] IntrPC = '0, JumpPc = '0;
    logic        ARVALID, ARREADY = 1'b1;
    logic [31:0] ARADDR;
    logic        RVALID = 1'b0, RREADY;
    logic [63:0] inst_i = '0;
    logic        ifu_valid, idu_ready = 1'b1;
    logic [31:0] inst_o;
    logic [63:0] pc_o;

    always #5 clk = ~clk;

    ifu_prefetch_queue #(
        .XLEN(64), .ADDR_W(32), .BUS_W(64), .INST_W(32),
        .FIFO_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(64'h8000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .isIntrPC(isIntrPC), .IntrPC(IntrPC), .is_jump(is_jump), .JumpPc(JumpPc),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
        .RVALID(RVALID), .RREADY(RREADY), .inst_i(inst_i),
        .ifu_valid(ifu_valid), .idu_ready(idu_ready), .inst_o(inst_o), .pc_o(pc_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        rq[$];
    logic [31:0] ar_log[$];
    logic [63:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          got_cyc[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc = 0, lat = 1, r_first = -1, v_first = -1;
    logic        s_arvalid = 1'b0;
    logic [31:0] s_araddr = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [63:0] word_at(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:3], 3'b000};
        return {inst_at(base + 32'd4), inst_at(base)};
    endfunction

    function automatic logic [63:0] at_pc(input int i);
        return (i < got_pc.size()) ? got_pc[i] : SENT;
    endfunction

    function automatic logic [63:0] at_inst(input int i);
        return (i < got_inst.size()) ? 64'(got_inst[i]) : SENT;
    endfunction

    function automatic logic [63:0] at_ar(input int i);
        return (i < ar_log.size()) ? 64'(ar_log[i]) : SENT;
    endfunction

    // Sample handshakes mid-cycle, then drive the next cycle's R beat after the edge.
    task automatic step();
        @(negedge clk);
        s_arvalid = ARVALID;
        s_araddr  = ARADDR;
        if (ARVALID && ARREADY) begin
            ar_log.push_back(ARADDR);
            rq.push_back('{ARADDR, cyc + lat});
        end
        if (ifu_valid && v_first < 0) v_first = cyc;
        if (ifu_valid && idu_ready) begin
            got_pc.push_back(pc_o);
            got_inst.push_back(inst_o);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            RVALID = 1'b1;
            inst_i = word_at(rq[0].addr);
            if (r_first < 0) r_first = cyc;
            rq.delete(0);
        end else begin
            RVALID = 1'b0;
            inst_i = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ARREADY = 1'b1; RVALID = 1'b0; inst_i = '0; idu_ready = 1'b1;
        is_jump = 1'b0; isIntrPC = 1'b0; JumpPc = '0; IntrPC = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", 64'(ARVALID), 64'd0);
        chk("rst_ifu_valid", 64'(ifu_valid), 64'd0);
        chk("rst_inst_o", 64'(inst_o), 64'd0);
        chk("rst_pc_o", pc_o, 64'd0);
        chk("rst_rready", 64'(RREADY), 64'd1);
        rq.delete(); ar_log.delete(); got_pc.delete(); got_inst.delete(); got_cyc.delete();
        r_first = -1; v_first = -1; lat = 1; s_arvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar_mark, got_mark, k;

        // 1: streaming, lanes alternate with pc[2]
        do_reset();
        repeat (16) step();
        for (int i = 0; i < 6; i++) begin
            chk("t1_araddr", at_ar(i), 64'h8000_0000 + 64'(4 * i));
            chk("t1_pc", at_pc(i), 64'h8000_0000 + 64'(4 * i));
            chk("t1_inst", at_inst(i), 64'hA5A5_0000 + 64'(4 * i));
        end

        // 2: IDU stalled, queue fills to depth without overflow, drains gap-free
        do_reset();
        idu_ready = 1'b0;
        repeat (20) step();
        chk("t2_ar_count", 64'(ar_log.size()), 64'd4);
        chk("t2_arvalid_low", 64'(s_arvalid), 64'd0);
        chk("t2_none_taken", 64'(got_pc.size()), 64'd0);
        chk("t2_valid", 64'(ifu_valid), 64'd1);
        chk("t2_head_pc", pc_o, 64'h8000_0000);
        chk("t2_head_inst", 64'(inst_o), 64'hA5A5_0000);
        idu_ready = 1'b1;
        repeat (10) step();
        for (int i = 0; i < 5; i++)
            chk("t2_drain_pc", at_pc(i), 64'h8000_0000 + 64'(4 * i));
        chk("t2_no_gap", (got_cyc.size() >= 4) ? 64'(got_cyc[3] - got_cyc[0]) : SENT, 64'd3);

        // 3: jump with two reads in flight
        do_reset();
        lat = 3;
        for (k = 0; k < 10 && ar_log.size() < 2; k++) step();
        chk("t3_two_inflight", 64'(ar_log.size()), 64'd2);
        JumpPc = 64'h8000_0100; is_jump = 1'b1;
        step();
        is_jump = 1'b0;
        ar_mark = ar_log.size(); got_mark = got_pc.size();
        repeat (15) step();
        chk("t3_none_before", 64'(got_mark), 64'd0);
        chk("t3_next_ar", at_ar(ar_mark), 64'h8000_0100);
        chk("t3_next_pc", at_pc(got_mark), 64'h8000_0100);
        chk("t3_next_inst", at_inst(got_mark), 64'hA5A5_0100);
        chk("t3_after_pc", at_pc(got_mark + 1), 64'h8000_0104);

        // 4: interrupt and jump together, interrupt wins
        do_reset();
        repeat (5) step();
        IntrPC = 64'h8000_0200; JumpPc = 64'h8000_0300;
        isIntrPC = 1'b1; is_jump = 1'b1;
        step();
        isIntrPC = 1'b0; is_jump = 1'b0;
        ar_mark = ar_log.size(); got_mark = got_pc.size();
        repeat (12) step();
        chk("t4_next_ar", at_ar(ar_mark), 64'h8000_0200);
        chk("t4_next_pc", at_pc(got_mark), 64'h8000_0200);
        chk("t4_next_inst", at_inst(got_mark), 64'hA5A5_0200);
        chk("t4_after_pc", at_pc(got_mark + 1), 64'h8000_0204);
        chk("t4_after_inst", at_inst(got_mark + 1), 64'hA5A5_0204);

        // 5: AR stalled 5 cycles, redirect in cycle 2
        do_reset();
        ARREADY = 1'b0;
        for (k = 0; k < 10 && !s_arvalid; k++) step();
        chk("t5_arvalid_up", 64'(s_arvalid), 64'd1);
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin
                JumpPc = 64'h8000_0400; is_jump = 1'b1;
            end
            step();
            is_jump = 1'b0;
            chk("t5_ar_hold", 64'({s_arvalid, s_araddr}), 64'h1_8000_0000);
        end
        ARREADY = 1'b1;
        repeat (12) step();
        chk("t5_ar0", at_ar(0), 64'h8000_0000);
        chk("t5_ar1", at_ar(1), 64'h8000_0400);
        chk("t5_first_pc", at_pc(0), 64'h8000_0400);
        chk("t5_first_inst", at_inst(0), 64'hA5A5_0400);

        // 6: R-beat to ifu_valid latency on an empty queue
        do_reset();
        lat = 2;
        repeat (10) step();
`ifdef IFU_BYPASS_EN
        chk("t6_latency", (r_first < 0 || v_first < 0) ? SENT : 64'(v_first - r_first), 64'd0);
`else
        chk("t6_latency", (r_first < 0 || v_first < 0) ? SENT : 64'(v_first - r_first), 64'd1);
`endif
        chk("t6_first_pc", at_pc(0), 64'h8000_0000);
        chk("t6_first_inst", at_inst(0), 64'hA5A5_0000);
        chk("t6_second_inst", at_inst(1), 64'hA5A5_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
